// File: rtl/reg_bank_scoreboard_pkg.sv
// Shared constants and helpers for the register bank with busy scoreboard.
package reg_bank_scoreboard_pkg;

    localparam int unsigned REG_ZERO   = 0;
    localparam logic [3:0]  OP_NOWRITE = 4'b1111;

    // Address width for a bank of the given depth; never narrower than one bit.
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/reg_bank_read_port.sv
// One asynchronous read port: register mux, write bypass and busy qualification.
module reg_bank_read_port
    import reg_bank_scoreboard_pkg::*;
#(
    parameter int unsigned  WIDTH    = 32,
    parameter int unsigned  DEPTH    = 16,
    parameter bit           ZERO_REG = 1'b0,
    parameter bit           BYPASS   = 1'b1,
    localparam int unsigned AW       = addr_width(DEPTH)
) (
    input  logic [DEPTH-1:0][WIDTH-1:0] regs,
    input  logic [DEPTH-1:0]            busy_vec,
    input  logic                        wr_en,
    input  logic [AW-1:0]               wr_addr,
    input  logic [WIDTH-1:0]            wr_data,
    input  logic [AW-1:0]               rd_addr,
    output logic [WIDTH-1:0]            rd_data_c,
    output logic                        busy_c
);

    logic zero_hit;
    logic wr_hit;

    // An in-flight writeback both forwards its data and retires the hazard.
    always_comb begin
        zero_hit  = ZERO_REG && (rd_addr == AW'(REG_ZERO));
        wr_hit    = wr_en && (wr_addr == rd_addr);
        rd_data_c = regs[rd_addr];
        busy_c    = busy_vec[rd_addr];
        if (BYPASS) begin
            if (wr_hit) begin
                rd_data_c = wr_data;
            end
            busy_c = busy_vec[rd_addr] && !wr_hit;
        end
        if (zero_hit) begin
            rd_data_c = '0;
            busy_c    = 1'b0;
        end
    end

endmodule

// File: rtl/reg_bank_scoreboard.sv
// Clocked register bank with two bypassed read ports and a per-register busy scoreboard.
module reg_bank_scoreboard
    import reg_bank_scoreboard_pkg::*;
#(
    parameter int unsigned  WIDTH    = 32,
    parameter int unsigned  DEPTH    = 16,
    parameter bit           ZERO_REG = 1'b0,
    parameter bit           BYPASS   = 1'b1,
    localparam int unsigned AW       = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr0,
    output logic [WIDTH-1:0] rd_data0,
    input  logic [AW-1:0]    rd_addr1,
    output logic [WIDTH-1:0] rd_data1,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_addr,
    output logic             busy0,
    output logic             busy1,
    output logic             rsv_stall,
    output logic [AW:0]      pending_cnt
);

    localparam int unsigned CW = AW + 1;

    logic [DEPTH-1:0][WIDTH-1:0] regs_q;
    logic [DEPTH-1:0][WIDTH-1:0] regs_d;
    logic [DEPTH-1:0]            busy_q;
    logic [DEPTH-1:0]            busy_d;
    logic [CW-1:0]               cnt_q;
    logic [CW-1:0]               cnt_d;
    logic                        wr_ok;
    logic                        rsv_zero;
    logic                        rsv_ok;
    logic                        cnt_inc;
    logic                        cnt_dec;

    // Next state: writeback clears busy, an accepted reservation sets it last so it wins.
    always_comb begin
        regs_d    = regs_q;
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        wr_ok     = wr_en && !(ZERO_REG && (wr_addr == AW'(REG_ZERO)));
        rsv_zero  = ZERO_REG && (rsv_addr == AW'(REG_ZERO));
        rsv_stall = rsv_en && !rsv_zero && busy_q[rsv_addr]
                    && !(wr_en && (wr_addr == rsv_addr));
        rsv_ok    = rsv_en && !rsv_zero && !rsv_stall;

        if (wr_ok) begin
            regs_d[wr_addr] = wr_data;
            busy_d[wr_addr] = 1'b0;
        end
        if (rsv_ok) begin
            busy_d[rsv_addr] = 1'b1;
        end

        // Count only real 0->1 and 1->0 transitions of the busy bits.
        cnt_inc = rsv_ok && !busy_q[rsv_addr];
        cnt_dec = wr_ok && busy_q[wr_addr] && !(rsv_ok && (rsv_addr == wr_addr));
        if (cnt_inc && !cnt_dec) begin
            cnt_d = cnt_q + CW'(1);
        end else if (cnt_dec && !cnt_inc) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pending_cnt = cnt_q;

    reg_bank_read_port #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .ZERO_REG(ZERO_REG),
        .BYPASS  (BYPASS)
    ) u_port0 (
        .regs     (regs_q),
        .busy_vec (busy_q),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr0),
        .rd_data_c(rd_data0),
        .busy_c   (busy0)
    );

    reg_bank_read_port #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .ZERO_REG(ZERO_REG),
        .BYPASS  (BYPASS)
    ) u_port1 (
        .regs     (regs_q),
        .busy_vec (busy_q),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr1),
        .rd_data_c(rd_data1),
        .busy_c   (busy1)
    );

endmodule

// File: tb/tb_reg_bank_scoreboard.sv
// Scoreboard bench: three configurations share stimulus, checked against an array model.
module tb_reg_bank_scoreboard;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;
    localparam int          NI    = 3;

    typedef struct packed {
        logic [WIDTH-1:0] rd0;
        logic [WIDTH-1:0] rd1;
        logic             b0;
        logic             b1;
        logic             stall;
        logic [AW:0]      cnt;
    } exp_t;
    typedef exp_t [NI-1:0] trio_t;

    logic             clk;
    logic             rst_n;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [AW-1:0]    rd_addr0;
    logic [AW-1:0]    rd_addr1;
    logic             rsv_en;
    logic [AW-1:0]    rsv_addr;

    logic [WIDTH-1:0] rd_data0 [NI];
    logic [WIDTH-1:0] rd_data1 [NI];
    logic             busy0 [NI];
    logic             busy1 [NI];
    logic             rsv_stall [NI];
    logic [AW:0]      pending_cnt [NI];

    int vectors     = 0;
    int miscompares = 0;

    logic [WIDTH-1:0] mem [NI][DEPTH];
    bit               bsy [NI][DEPTH];
    trio_t            expq [$];

    reg_bank_scoreboard #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(1'b0), .BYPASS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr0(rd_addr0), .rd_data0(rd_data0[0]), .rd_addr1(rd_addr1), .rd_data1(rd_data1[0]),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy0(busy0[0]), .busy1(busy1[0]),
        .rsv_stall(rsv_stall[0]), .pending_cnt(pending_cnt[0]));

    reg_bank_scoreboard #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_z (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr0(rd_addr0), .rd_data0(rd_data0[1]), .rd_addr1(rd_addr1), .rd_data1(rd_data1[1]),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy0(busy0[1]), .busy1(busy1[1]),
        .rsv_stall(rsv_stall[1]), .pending_cnt(pending_cnt[1]));

    reg_bank_scoreboard #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr0(rd_addr0), .rd_data0(rd_data0[2]), .rd_addr1(rd_addr1), .rd_data1(rd_data1[2]),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy0(busy0[2]), .busy1(busy1[2]),
        .rsv_stall(rsv_stall[2]), .pending_cnt(pending_cnt[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 1 has the hardwired zero register, instance 2 has no bypass.
    function automatic bit has_zero(input int i);
        return i == 1;
    endfunction

    function automatic bit has_bypass(input int i);
        return i != 2;
    endfunction

    function automatic bit is_zero(input int i, input logic [AW-1:0] a);
        return has_zero(i) && (a == '0);
    endfunction

    function automatic logic [WIDTH-1:0] exp_rd(input int i, input logic [AW-1:0] a);
        if (is_zero(i, a)) return '0;
        if (has_bypass(i) && wr_en && (wr_addr == a)) return wr_data;
        return mem[i][a];
    endfunction

    function automatic logic exp_busy(input int i, input logic [AW-1:0] a);
        if (has_bypass(i) && wr_en && (wr_addr == a)) return 1'b0;
        return bsy[i][a];
    endfunction

    function automatic logic exp_stall(input int i);
        return rsv_en && !is_zero(i, rsv_addr) && bsy[i][rsv_addr]
               && !(wr_en && (wr_addr == rsv_addr));
    endfunction

    function automatic logic [AW:0] popcount(input int i);
        int n = 0;
        for (int k = 0; k < DEPTH; k++) n += int'(bsy[i][k]);
        return (AW+1)'(n);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++)
            for (int k = 0; k < DEPTH; k++) begin
                mem[i][k] = '0;
                bsy[i][k] = 1'b0;
            end
    endtask

    task automatic model_step();
        for (int i = 0; i < NI; i++) begin
            bit st;
            st = exp_stall(i);
            if (wr_en && !is_zero(i, wr_addr)) begin
                mem[i][wr_addr] = wr_data;
                bsy[i][wr_addr] = 1'b0;
            end
            if (rsv_en && !is_zero(i, rsv_addr) && !st) bsy[i][rsv_addr] = 1'b1;
        end
    endtask

    // Apply one cycle of stimulus at the falling edge and queue what every instance must show.
    task automatic drive(input bit rst, input bit we, input logic [AW-1:0] wa,
                         input logic [WIDTH-1:0] wd, input logic [AW-1:0] r0,
                         input logic [AW-1:0] r1, input bit re, input logic [AW-1:0] ra);
        trio_t t;
        @(negedge clk);
        rst_n = rst; wr_en = we; wr_addr = wa; wr_data = wd;
        rd_addr0 = r0; rd_addr1 = r1; rsv_en = re; rsv_addr = ra;
        if (!rst) model_reset();
        for (int i = 0; i < NI; i++) begin
            t[i].rd0   = exp_rd(i, r0);
            t[i].rd1   = exp_rd(i, r1);
            t[i].b0    = exp_busy(i, r0);
            t[i].b1    = exp_busy(i, r1);
            t[i].stall = exp_stall(i);
            t[i].cnt   = popcount(i);
        end
        expq.push_back(t);
        if (rst) model_step();
    endtask

    task automatic check(input string name, input int i, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s inst%0d t=%0t actual=%h required=%h", name, i, $time, act, exp);
        end
    endtask

    // Monitor: samples just before the next rising edge and compares against the queue head.
    initial begin
        trio_t t;
        forever begin
            @(negedge clk);
            #3;
            if (expq.size() != 0) begin
                t = expq.pop_front();
                for (int i = 0; i < NI; i++) begin
                    check("rd_data0", i, rd_data0[i], t[i].rd0);
                    check("rd_data1", i, rd_data1[i], t[i].rd1);
                    check("busy0", i, WIDTH'(busy0[i]), WIDTH'(t[i].b0));
                    check("busy1", i, WIDTH'(busy1[i]), WIDTH'(t[i].b1));
                    check("rsv_stall", i, WIDTH'(rsv_stall[i]), WIDTH'(t[i].stall));
                    check("pending_cnt", i, WIDTH'(pending_cnt[i]), WIDTH'(t[i].cnt));
                end
            end
        end
    end

    initial begin
        rst_n = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr0 = '0; rd_addr1 = '0; rsv_en = 1'b0; rsv_addr = '0;
        model_reset();
        #1 rst_n = 1'b0;

        drive(0, 0, 0, 0, 0, 1, 0, 0);
        for (int k = 0; k < DEPTH / 2; k++)
            drive(1, 0, 0, 0, AW'(2 * k), AW'(2 * k + 1), 0, 0);

        // Same-cycle bypass, then the stored value.
        drive(1, 1, 5, 32'hDEADBEEF, 5, 4, 0, 0);
        drive(1, 0, 0, 0, 5, 5, 0, 0);

        // Write and reserve register 0; then retire any busy it left behind.
        drive(1, 1, 0, 32'h1234, 0, 5, 1, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 3, 0, 0);

        // Reserve 3, re-reserve (stall), write back.
        drive(1, 0, 0, 0, 3, 0, 1, 3);
        drive(1, 0, 0, 0, 3, 0, 1, 3);
        drive(1, 1, 3, 32'hA5, 3, 0, 0, 0);
        drive(1, 0, 0, 0, 3, 3, 0, 0);

        // Register 7 busy, then write plus new reservation in the same cycle.
        drive(1, 0, 0, 0, 7, 0, 1, 7);
        drive(1, 1, 7, 32'h55, 7, 7, 1, 7);
        drive(1, 0, 0, 0, 7, 7, 0, 0);
        drive(1, 1, 7, 32'h77, 7, 0, 0, 0);

        // Fill the whole scoreboard, then drain it.
        for (int k = 0; k < DEPTH; k++)
            drive(1, 0, 0, 0, AW'(k), AW'(DEPTH - 1 - k), 1, AW'(k));
        drive(1, 0, 0, 0, 0, 15, 0, 0);
        for (int k = 0; k < DEPTH; k++)
            drive(1, 1, AW'(k), 32'h100 + k, AW'(k), AW'(k + 1), 0, 0);
        drive(1, 0, 0, 0, 1, 15, 0, 0);

        // Randomized traffic over a narrow address range to provoke hazards.
        for (int n = 0; n < 400; n++)
            drive(1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
                  AW'($urandom_range(0, 7)), AW'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)));

        // Asynchronous reset mid-run: outputs clear before any rising edge.
        drive(0, 0, 0, 0, 3, 5, 0, 0);
        drive(0, 0, 0, 0, 7, 1, 0, 0);
        for (int n = 0; n < 40; n++)
            drive(1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom,
                  AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)));

        @(negedge clk);
        #5;
        check("queue_drain", 0, WIDTH'(expq.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
